// File: rtl/fifo_uart_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: FSM encodings, line levels
// and a width helper.
package fifo_uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
  localparam logic [2:0] S_PARITY = 3'd6;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Bits needed to hold 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, wraps on its own and restarts on clr.
module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_done
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt;

  assign bit_done = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO and serialises each as an LSB-first UART frame on tx.
// Build option FIFO_UART_TX_PARITY_EN adds an even-parity bit (8E1); default is 8N1.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a non-empty FIFO
// S_POP    | one-cycle read strobe to the FIFO
// S_LOAD   | FIFO output valid; capture into shift register
// S_START  | start bit
// S_DATA   | DATA_W data bits, LSB first
// S_PARITY | even parity bit (parity builds only)
// S_STOP   | stop bit; chain straight into the next pop if data is waiting
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy
);

  localparam int BIT_W = clog2(DATA_W);

  logic [2:0]        state, state_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic              tx_nxt;
  logic              bit_done;
  logic              baud_clr;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity;
`endif

  // Every state change restarts the bit period.
  assign baud_clr = (state_nxt != state);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .bit_done (bit_done)
  );

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_POP;
      S_POP:   state_nxt = S_LOAD;
      S_LOAD: begin
        shift_nxt   = fifo_data;
        bit_cnt_nxt = '0;
        state_nxt   = S_START;
      end
      S_START: if (bit_done) state_nxt = S_DATA;
      S_DATA: begin
        if (bit_done) begin
          shift_nxt   = shift >> 1;
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: if (bit_done) state_nxt = S_STOP;
`endif
      S_STOP:  if (bit_done) state_nxt = fifo_empty ? S_IDLE : S_POP;
      default: state_nxt = S_IDLE;
    endcase
  end

  // tx is driven from the upcoming state so the pin toggles exactly on state entry.
  always_comb begin
    case (state_nxt)
      S_START:  tx_nxt = START_BIT;
      S_DATA:   tx_nxt = shift_nxt[0];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: tx_nxt = parity;
`endif
      S_STOP:   tx_nxt = STOP_BIT;
      default:  tx_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= IDLE_LEVEL;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx      <= tx_nxt;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity <= 1'b0;
    end else if (state == S_LOAD) begin
      parity <= ^fifo_data;
    end
  end
`endif

  assign fifo_rd = (state == S_POP);
  assign busy    = (state != S_IDLE);

endmodule
